apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 DATA_WIDTH, 32, APB data bus width.
REQ-002 ADDR_WIDTH, 32, APB address bus width.
REQ-003 NUM_REQ, 2, number of requester ports; legal range 2..8.
REQ-004 TIMEOUT, 16, maximum ACCESS-phase cycles allowed before abort; legal range 2..255.
Ports (name, direction, width, meaning):
REQ-005 PCLK  in  1  single clock; all logic is rising-edge.
REQ-006 PRESETn  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NUM_REQ  request pending, one bit per requester; held until accepted.
REQ-008 req_write  in  NUM_REQ  1=write, 0=read, per requester.
REQ-009 req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
REQ-010 req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies slice i.
REQ-011 req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-012 rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; valid while rsp_valid is nonzero.
REQ-014 rsp_err  out  1  error flag (PSLVERR or timeout); valid while rsp_valid is nonzero.
REQ-015 PSELx, PENABLE, PWRITE  out  1 each  APB master controls, registered.
REQ-016 PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH  registered APB address and write data.
REQ-017 PREADY  in  1; PRDATA  in  DATA_WIDTH; PSLVERR  in  1  APB slave response.

Function
REQ-018 The FSM SHALL have three states, IDLE, SETUP and ACCESS: IDLE drives PSELx=0 and PENABLE=0; SETUP drives PSELx=1 and PENABLE=0; ACCESS drives PSELx=1 and PENABLE=1.
REQ-019 In IDLE, when any req_valid bit is set, the block SHALL grant one requester by round-robin, searching from (last_grant+1) mod NUM_REQ upward.
REQ-020 Grant handling SHALL assert req_ready[grant] combinationally in that same IDLE cycle.
REQ-021 At the next edge, the granted requester's write, address and data SHALL be latched onto PWRITE, PADDR and PWDATA, last_grant SHALL be updated, and the state SHALL move to SETUP.
REQ-022 SETUP SHALL move to ACCESS unconditionally after one cycle.
REQ-023 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS.
REQ-024 In ACCESS with PREADY=1, the next edge SHALL set state=IDLE, deassert PSELx and PENABLE, pulse rsp_valid[grant] for one cycle, and load rsp_err=PSLVERR.
REQ-025 On that completion, rsp_rdata SHALL load PRDATA for a read and 0 for a write.
REQ-026 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-027 In the ACCESS cycle where the wait count equals TIMEOUT-1 and PREADY=0, the block SHALL complete the transfer as in REQ-024 with rsp_err=1 and rsp_rdata=0 (timeout abort).
REQ-028 Latency SHALL be: accept in cycle T, SETUP at T+1, ACCESS at T+2; with zero wait states, rsp_valid is high at T+3.
REQ-029 The block SHALL accept a new request in the same cycle rsp_valid is high, giving 3-cycle back-to-back throughput.
REQ-030 req_valid changes during SETUP or ACCESS SHALL NOT affect the transfer in flight; at most one transfer SHALL be outstanding.
REQ-031 req_ready SHALL be 0 in SETUP and ACCESS, and at most one req_ready bit SHALL be set in any cycle.
REQ-032 A requester that deasserts req_valid before it is granted SHALL lose its turn with no side effects.
REQ-033 A requester asserting req_valid continuously SHALL NOT be granted twice in a row while another requester is waiting.

Reset
REQ-034 While PRESETn=0, the block SHALL force, asynchronously: state=IDLE; PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter to 0; last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
REQ-035 A reset asserted mid-transfer SHALL abort the transfer with no rsp_valid pulse for it; the first grant after reset release SHALL follow REQ-034.

Verification
REQ-036 Single read: req_valid=01, req_addr[0]=0x10, slave PREADY=1, PRDATA=0xDEADBEEF -> req_ready=01 at T, PSELx at T+1, PENABLE at T+2, rsp_valid=01 with rsp_rdata=0xDEADBEEF and rsp_err=0 at T+3.
REQ-037 Contention: req_valid=11 held through 4 transfers -> grants in order 0,1,0,1, each rsp_valid to the matching requester, 3 cycles apart.
REQ-038 Wait states: write of 0xA5A5A5A5 to 0x04, PREADY low for 3 ACCESS cycles -> PADDR and PWDATA stable throughout, rsp_valid 6 cycles after accept, rsp_rdata=0, rsp_err=0.
REQ-039 Slave error: PSLVERR=1 with PREADY=1 on a read -> rsp_err=1 and rsp_rdata=PRDATA for one cycle.
REQ-040 Timeout: TIMEOUT=16, PREADY held 0 -> after 16 ACCESS cycles PSELx drops, rsp_valid pulses with rsp_err=1 and rsp_rdata=0, and the next request is served normally.
REQ-041 Reset mid-ACCESS: PRESETn pulled low -> PSELx and PENABLE go low without waiting for an edge, no rsp_valid pulse, and with req_valid=11 after release, requester 0 is granted first.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter feeding a single APB master port
module apb_master_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REQ    = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                            PCLK,
   input  logic                            PRESETn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic                            rsp_err,
   output logic                            PSELx,
   output logic                            PENABLE,
   output logic                            PWRITE,
   output logic [ADDR_WIDTH-1:0]           PADDR,
   output logic [DATA_WIDTH-1:0]           PWDATA,
   input  logic                            PREADY,
   input  logic [DATA_WIDTH-1:0]           PRDATA,
   input  logic                            PSLVERR
);
   localparam int GW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state, state_n;
   logic [GW-1:0] last_grant, grant;
   logic [NUM_REQ-1:0] rot;
   logic [7:0] wait_cnt;
   logic found, accept, done;
   assign rot = NUM_REQ'({req_valid, req_valid} >> (last_grant + 1'b1));
   // pick the first pending requester after the previous winner
   always_comb begin
      grant = last_grant;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            grant = GW'((int'(last_grant) + 1 + i) % NUM_REQ);
            found = 1'b1;
         end
      end
   end
   // next state, accept pulse and completion detection (PREADY or timeout)
   always_comb begin
      accept    = state == IDLE && |req_valid;
      done      = state == ACCESS && (PREADY || wait_cnt == 8'(TIMEOUT - 1));
      req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
      state_n   = state == IDLE  ? (accept ? SETUP : IDLE) :
                  state == SETUP ? ACCESS :
                  done           ? IDLE : ACCESS;
   end
   // state register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_n;
   end
   // registered APB controls, captured request, wait counter and response
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PSELx      <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         wait_cnt   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
      end else begin
         PSELx     <= state_n != IDLE;
         PENABLE   <= state_n == ACCESS;
         rsp_valid <= done ? (NUM_REQ'(1) << last_grant) : '0;
         wait_cnt  <= state == SETUP ? '0 : (state == ACCESS && !PREADY) ? wait_cnt + 1'b1 : wait_cnt;
         if (accept) begin
            last_grant <= grant;
            PWRITE     <= req_write[grant];
            PADDR      <= req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
            PWDATA     <= req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
         end
         if (done) begin
            rsp_err   <= !PREADY || PSLVERR;
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
         end
      end
   end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized transfers checked against a transaction-level model
module tb_apb_master_arbiter;
   localparam int N = 3, AW = 32, DW = 32, TO = 16;
   logic PCLK = 1'b0, PRESETn = 1'b0;
   logic [N-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [DW-1:0] rsp_rdata, PWDATA, PRDATA = '0;
   logic [AW-1:0] PADDR;
   logic rsp_err, PSELx, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
   int n_chk = 0, n_fail = 0, last_g = N - 1, exp_g = 0;
   bit exp_rsp = 0, exp_err = 0;
   logic [DW-1:0] exp_rdata = '0;

   apb_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR));

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] m);
      int c = last_g;
      repeat (N) begin
         c = (c + 1) % N;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i] = w;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic scramble();
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom), $urandom, $urandom);
   endtask

   task automatic check_rsp();
      chk("rsp_valid", rsp_valid, exp_rsp ? N'(1) << exp_g : N'(0));
      if (exp_rsp) begin
         chk("rsp_err", rsp_err, exp_err);
         chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
      exp_rsp = 0;
   endtask

   task automatic idle();
      @(negedge PCLK);
      req_valid = '0;
      PREADY = 1'b0;
      #1;
      check_rsp();
      chk("ready_idle", req_ready, 0);
      chk("psel_idle", PSELx, 0);
      chk("penable_idle", PENABLE, 0);
   endtask

   task automatic xfer(input logic [N-1:0] mask, input int waits, input bit err, input logic [DW-1:0] rd);
      int g, k;
      bit wr, fin;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      @(negedge PCLK);
      req_valid = mask;
      PREADY = 1'b0;
      PSLVERR = 1'b0;
      #1;
      check_rsp();
      g = rr_pick(mask);
      chk("req_ready", req_ready, N'(1) << g);
      chk("psel_accept", PSELx, 0);
      wr = req_write[g];
      a = req_addr[g*AW +: AW];
      wd = req_wdata[g*DW +: DW];
      last_g = g;
      @(negedge PCLK);
      req_valid = N'($urandom);
      scramble();
      #1;
      chk("ready_setup", req_ready, 0);
      chk("psel_setup", PSELx, 1);
      chk("penable_setup", PENABLE, 0);
      chk("paddr_setup", PADDR, a);
      chk("pwrite_setup", PWRITE, wr);
      chk("pwdata_setup", PWDATA, wd);
      k = 0;
      fin = 0;
      while (!fin) begin
         @(negedge PCLK);
         PREADY = k >= waits;
         PSLVERR = PREADY ? err : 1'($urandom);
         PRDATA = PREADY ? rd : $urandom;
         req_valid = N'($urandom);
         #1;
         chk("psel_access", PSELx, 1);
         chk("penable_access", PENABLE, 1);
         chk("paddr_access", PADDR, a);
         chk("pwdata_access", PWDATA, wd);
         chk("pwrite_access", PWRITE, wr);
         chk("rsp_valid_busy", rsp_valid, 0);
         chk("ready_access", req_ready, 0);
         fin = PREADY || k == TO - 1;
         k++;
      end
      exp_rsp = 1;
      exp_g = g;
      exp_err = PREADY ? err : 1'b1;
      exp_rdata = (PREADY && !wr) ? rd : '0;
   endtask

   initial begin
      int g, w;
      logic [N-1:0] m;
      repeat (2) @(negedge PCLK);
      #1;
      chk("rst_psel", PSELx, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_ready", req_ready, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      scramble();
      set_req(0, 1'b0, 32'h10, 32'h0);
      xfer(3'b001, 0, 0, 32'hDEADBEEF);
      scramble();
      set_req(1, 1'b1, 32'h04, 32'hA5A5A5A5);
      xfer(3'b010, 3, 0, $urandom);
      scramble();
      set_req(2, 1'b0, $urandom, $urandom);
      xfer(3'b100, 0, 1, 32'h12345678);
      scramble();
      xfer(3'b001, 100, 0, $urandom);
      scramble();
      xfer(3'b011, 0, 0, $urandom);
      repeat (200) begin
         if ($urandom_range(0, 4) == 0) idle();
         scramble();
         m = N'($urandom_range(1, (1 << N) - 1));
         case ($urandom_range(0, 9))
            0: w = TO - 1;
            1: w = TO + 5;
            default: w = $urandom_range(0, 3);
         endcase
         xfer(m, w, 1'($urandom), $urandom);
      end
      idle();
      @(negedge PCLK);
      req_valid = 3'b111;
      #1;
      g = rr_pick(3'b111);
      chk("ready_pre_reset", req_ready, N'(1) << g);
      @(negedge PCLK);
      req_valid = '0;
      @(negedge PCLK);
      PREADY = 1'b0;
      #1;
      chk("penable_pre_reset", PENABLE, 1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("psel_async_rst", PSELx, 0);
      chk("penable_async_rst", PENABLE, 0);
      repeat (2) begin
         @(negedge PCLK);
         #1;
         chk("rsp_valid_in_rst", rsp_valid, 0);
      end
      @(negedge PCLK);
      PRESETn = 1'b1;
      last_g = N - 1;
      exp_rsp = 0;
      idle();
      idle();
      for (int i = 0; i < 4; i++) begin
         scramble();
         xfer(3'b011, 0, 0, $urandom);
         chk("contention_order", exp_g, i % 2);
      end
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
